// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the PC, issues single-cycle-latency reads to
// instruction memory and buffers returned {instr, pc} pairs in a prefetch FIFO.
module fetch_unit #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_L  = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0]  fetch_pc_r;
  logic               run_r;
  logic               pend_valid_r;
  logic [ADDR_W-1:0]  pend_pc_r;
  logic [INSTR_W-1:0] fifo_instr_r [DEPTH];
  logic [ADDR_W-1:0]  fifo_pc_r    [DEPTH];
  logic [PTR_W-1:0]   head_r;
  logic [PTR_W-1:0]   tail_r;
  logic [CNT_W-1:0]   count_r;

  logic [CNT_W:0]     inflight_s;
  logic               issue_s;
  logic               push_s;
  logic               pop_s;
  logic               instr_valid_s;

  // Issue credit counts buffered plus in-flight entries; a same-cycle pop earns no credit.
  always_comb begin
    inflight_s    = {1'b0, count_r} + {{CNT_W{1'b0}}, pend_valid_r};
    issue_s       = run_r && !redirect_valid && (inflight_s < DEPTH_L);
    push_s        = pend_valid_r && !redirect_valid;
    instr_valid_s = (count_r != {CNT_W{1'b0}}) && !redirect_valid;
    pop_s         = instr_valid_s && instr_ready;
  end

  // Output drive; head fields are masked to zero whenever nothing is offered.
  always_comb begin
    imem_rd_en  = issue_s;
    imem_addr   = fetch_pc_r;
    instr_valid = instr_valid_s;
    if (instr_valid_s) begin
      instr    = fifo_instr_r[head_r];
      instr_pc = fifo_pc_r[head_r];
    end else begin
      instr    = {INSTR_W{1'b0}};
      instr_pc = {ADDR_W{1'b0}};
    end
  end

  // PC, in-flight tracking and FIFO bookkeeping; redirect outranks pop, push and issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_r   <= {ADDR_W{1'b0}};
      run_r        <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_pc_r    <= {ADDR_W{1'b0}};
      head_r       <= {PTR_W{1'b0}};
      tail_r       <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
    end else begin
      run_r <= 1'b1;
      if (redirect_valid) begin
        fetch_pc_r   <= redirect_pc;
        pend_valid_r <= 1'b0;
        head_r       <= {PTR_W{1'b0}};
        tail_r       <= {PTR_W{1'b0}};
        count_r      <= {CNT_W{1'b0}};
      end else begin
        if (issue_s) begin
          pend_valid_r <= 1'b1;
          pend_pc_r    <= fetch_pc_r;
          fetch_pc_r   <= fetch_pc_r + PC_ONE;
        end else begin
          pend_valid_r <= 1'b0;
        end
        if (push_s) begin
          tail_r <= tail_r + PTR_ONE;
        end
        if (pop_s) begin
          head_r <= head_r + PTR_ONE;
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNT_ONE;
          2'b01:   count_r <= count_r - CNT_ONE;
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // FIFO storage; the returning read is written at the tail unless squashed by redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_r[i] <= {INSTR_W{1'b0}};
        fifo_pc_r[i]    <= {ADDR_W{1'b0}};
      end
    end else if (push_s) begin
      fifo_instr_r[tail_r] <= imem_rdata;
      fifo_pc_r[tail_r]    <= pend_pc_r;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, wrap, backpressure, redirect flush,
// back-to-back redirects and asynchronous reset mid-stream.
module tb_fetch_unit;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               imem_rd_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata = 16'h0000;
  logic               instr_valid;
  logic               instr_ready = 1'b0;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               redirect_valid = 1'b0;
  logic [ADDR_W-1:0]  redirect_pc = 4'd0;

  int n_cmp = 0;
  int n_err = 0;
  logic [INSTR_W-1:0] mem [16];

  fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_rd_en    (imem_rd_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  // synchronous instruction memory model, one-cycle read latency
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input int pc);
    logic [3:0] p;
    p = 4'(pc % 16);
    check_val({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check_val({tag, "_instr"}, 32'(instr), 32'h1000 + 32'(p));
    check_val({tag, "_pc"}, 32'(instr_pc), 32'(p));
  endtask

  // drops reset between edges, releases it, returns just after edge E0
  task automatic restart(input logic rdy);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = rdy;
    #1;
    check_val("rst_valid", 32'(instr_valid), 32'd0);
    check_val("rst_rden", 32'(imem_rd_en), 32'd0);
    check_val("rst_instr", 32'(instr), 32'd0);
    check_val("rst_addr", 32'(imem_addr), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic stream_from_start(input int n);
    check_val("s_rden0", 32'(imem_rd_en), 32'd1);
    check_val("s_addr0", 32'(imem_addr), 32'd0);
    check_val("s_valid0", 32'(instr_valid), 32'd0);
    tick();
    check_val("s_addr1", 32'(imem_addr), 32'd1);
    check_val("s_valid1", 32'(instr_valid), 32'd0);
    tick();
    for (int k = 0; k < n; k++) begin
      chk_head("stream", k);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);

    // streaming and wrap
    restart(1'b1);
    stream_from_start(20);

    // asynchronous reset mid-stream, then power-on style restart
    check_val("pre_rst_valid", 32'(instr_valid), 32'd1);
    restart(1'b1);
    stream_from_start(5);

    // backpressure from reset
    restart(1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk_head("bp_full", 0);
    check_val("bp_rden", 32'(imem_rd_en), 32'd0);
    check_val("bp_fetch_pc", 32'(imem_addr), 32'd4);
    tick();
    chk_head("bp_stable", 0);
    check_val("bp_rden2", 32'(imem_rd_en), 32'd0);
    instr_ready = 1'b1;
    #1;
    check_val("bp_nocredit", 32'(imem_rd_en), 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk_head("bp_drain", k);
      if (k == 1) begin
        check_val("bp_refill_rden", 32'(imem_rd_en), 32'd1);
        check_val("bp_refill_addr", 32'(imem_addr), 32'd4);
      end
      tick();
    end

    // redirect flush: 3 buffered, 1 in flight
    restart(1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk_head("rf_pre", 0);
    check_val("rf_pre_rden", 32'(imem_rd_en), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 4'd9;
    instr_ready = 1'b1;
    #1;
    check_val("rf_R_valid", 32'(instr_valid), 32'd0);
    check_val("rf_R_rden", 32'(imem_rd_en), 32'd0);
    check_val("rf_R_instr", 32'(instr), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_val("rf_R1_valid", 32'(instr_valid), 32'd0);
    check_val("rf_R1_rden", 32'(imem_rd_en), 32'd1);
    check_val("rf_R1_addr", 32'(imem_addr), 32'd9);
    tick();
    check_val("rf_R2_valid", 32'(instr_valid), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk_head("rf_post", 9 + k);
      tick();
    end

    // redirect with handshake at count 2, back-to-back redirects 5 then 12
    restart(1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk_head("rh_pre", 0);
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 4'd5;
    #1;
    check_val("rh_R_valid", 32'(instr_valid), 32'd0);
    tick();
    redirect_pc = 4'd12;
    #1;
    check_val("rh_R1_valid", 32'(instr_valid), 32'd0);
    check_val("rh_R1_rden", 32'(imem_rd_en), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_val("rh_R2_valid", 32'(instr_valid), 32'd0);
    check_val("rh_R2_rden", 32'(imem_rd_en), 32'd1);
    check_val("rh_R2_addr", 32'(imem_addr), 32'd12);
    tick();
    check_val("rh_R3_valid", 32'(instr_valid), 32'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk_head("rh_post", 12 + k);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front-end for the 16-bit pipelined CPU. It owns the program counter, issues reads to the synchronous instruction memory, and buffers returned instructions in a small prefetch FIFO. The decode stage consumes them through a valid/ready handshake. A single-cycle redirect flushes the FIFO and any in-flight read, then restarts fetch at a new PC.

## Interface
- ADDR_W, 4, instruction address / PC width (16-entry instruction memory)
- INSTR_W, 16, instruction width
- DEPTH, 4, prefetch FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_rd_en  out  1  read strobe to instruction memory
- imem_addr  out  ADDR_W  read address; equals fetch_pc
- imem_rdata  in  INSTR_W  read data, valid the cycle after imem_rd_en
- instr_valid  out  1  head of FIFO holds an instruction for decode
- instr_ready  in  1  decode accepts the instruction this cycle
- instr  out  INSTR_W  head instruction; 0 when instr_valid low
- instr_pc  out  ADDR_W  address of head instruction; 0 when instr_valid low
- redirect_valid  in  1  one-cycle request to restart fetch
- redirect_pc  in  ADDR_W  new fetch address, sampled when redirect_valid high

## Operation
- State:
  - fetch_pc (ADDR_W)
  - run flag
  - pend_valid / pend_pc, tracking the single read in flight
  - FIFO entries holding {instr, pc}, with head and tail pointers and a count of 0..DEPTH
- Reset (reset_n low, asynchronous): fetch_pc=0, run=0, pend_valid=0, count=0, pointers=0, entries=0. All outputs go low/0 immediately and stay there while reset is held.
- run is set at the first rising edge with reset_n high. imem_rd_en stays low until run=1.
- Issue:
  - imem_rd_en = run && !redirect_valid && (count + pend_valid) < DEPTH. This is combinational; no credit is taken for a same-cycle pop.
  - On issue: pend_valid<=1, pend_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^ADDR_W, so 15 wraps to 0).
  - With no issue: pend_valid<=0.
- Return: when pend_valid=1 and redirect_valid=0, push {imem_rdata, pend_pc} at the tail. The credit rule guarantees the FIFO never overflows, so there is no overflow path.
- Output:
  - instr_valid = (count != 0) && !redirect_valid.
  - Pop when instr_valid && instr_ready.
  - Simultaneous push and pop leaves count unchanged.
- Redirect (redirect_valid=1) at that edge:
  - count<=0, head/tail<=0, pend_valid<=0
  - fetch_pc<=redirect_pc
  - No push and no pop that cycle. Returning data for the squashed read is discarded.
  - A redirect_valid held high for several cycles repeats this each cycle; the last redirect_pc wins.
- Entries are dropped only by redirect or reset. Without a redirect, order is strictly increasing PC modulo 16, with no loss and no duplication.

## Timing
- Read latency: imem_rd_en/imem_addr in cycle T gives imem_rdata in cycle T+1. The push happens at the end of T+1, so instr_valid/instr is visible in cycle T+2 when the FIFO was empty. Fetch-to-decode latency is 2 cycles.
- After reset release, edge E0 sets run. The first imem_rd_en (addr 0) is in the cycle after E0. The first instr_valid (pc 0) is two cycles later.
- Throughput: 1 instruction/cycle sustained with instr_ready held high.
- Backpressure: with instr_ready=0 the FIFO fills to exactly DEPTH entries. imem_rd_en then drops and fetch_pc holds at (head pc + DEPTH) mod 16. instr/instr_pc stay stable while valid and not accepted.
- Redirect in cycle R:
  - instr_valid is low in R, and in R+1 because count=0.
  - The read of redirect_pc issues in R+1.
  - The first post-redirect instruction appears in R+3.
- Redirect has priority over pop, push and issue. Reset has priority over everything.
- Asynchronous reset mid-stream clears all state with no partial writes. The restart sequence matches power-on.

## Test plan
- Streaming: preload mem[i]=16'h1000+i, instr_ready=1, release reset. Required: instr 16'h1000, 16'h1001, … on consecutive cycles, with instr_pc 0,1,2…; first valid 3 cycles after E0 (at the clock level: the cycle following the third rising edge after reset release).
- Backpressure: hold instr_ready=0 from reset. Required: count=4, imem_rd_en low, fetch_pc=4, instr=16'h1000 stable. Then raise instr_ready. Required: 16'h1000..16'h1003 back-to-back, then 16'h1004 onward with no gap beyond the 2-cycle refill and no duplicates.
- Wrap: stream 20 instructions. Required: pc sequence …14,15,0,1…; instr 16'h100F followed by 16'h1000.
- Redirect flush: FIFO holding 3 entries, one read in flight, pulse redirect_valid with redirect_pc=9. Required: instr_valid low in R and R+1, imem_addr=9 in R+1, instr=16'h1009 with pc 9 in R+3, and no stale pre-redirect instruction ever delivered.
- Redirect with handshake: redirect_valid=1 while count=2 and instr_ready=1. Required: no pop counted and no push. Back-to-back redirects to 5 then 12 deliver only pc 12 onward.
- Async reset mid-stream: drop reset_n between edges while streaming. Required: instr_valid and imem_rd_en go low immediately. After release, the sequence restarts at pc 0 with 16'h1000.
